// File: rtl/mux8_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mux8_rr_arbiter
//
// Round-robin arbiter for eight requesters with a 1-bit 8:1 datapath mux.
// The granted requester keeps ownership for at most MAX_BEATS transfers,
// or until it drops its request. At least one IDLE cycle always separates
// two grants.
//
// Parameters
//   MAX_BEATS  maximum transfers per grant (1..15)
//
// Ports
//   clk        clock; all state changes on its rising edge
//   rst        synchronous, active-high reset
//   req[7:0]   request lines, one per requester
//   data_in    one data bit per requester (8:1 datapath inputs)
//   out_ready  sink accepts the current beat
//   gnt[7:0]   registered one-hot grant
//   out_sel    registered index of the granted requester (held in IDLE)
//   out_valid  busy AND req[out_sel]
//   out_data   data_in[out_sel] while busy, else 0
//   busy       high while a grant is active
// ----------------------------------------------------------------------------
module mux8_rr_arbiter #(
    parameter int MAX_BEATS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] data_in,
    input  logic       out_ready,
    output logic [7:0] gnt,
    output logic [2:0] out_sel,
    output logic       out_valid,
    output logic       out_data,
    output logic       busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [3:0] LAST_BEAT = 4'(MAX_BEATS - 1);

    logic [0:0] state_reg,    state_next;
    logic [2:0] last_reg,     last_next;
    logic [3:0] beat_cnt_reg, beat_cnt_next;
    logic [7:0] gnt_reg,      gnt_next;
    logic [2:0] out_sel_reg,  out_sel_next;

    // ------------------------------------------------------------------
    // Round-robin search.
    // rot_req[k] is the request of requester (last+1+k) mod 8, so the
    // lowest set bit of rot_req is the winner. For k=7 the index wraps
    // back to last itself, which lets a lone persistent requester win again.
    // ------------------------------------------------------------------
    logic [7:0] rot_req;
    logic [2:0] win_off;
    logic [2:0] winner;
    logic [7:0] winner_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rot
            logic [2:0] idx;
            assign idx         = last_reg + 3'(gi + 1);
            assign rot_req[gi] = req[idx];
        end

        for (gi = 0; gi < 8; gi++) begin : g_onehot
            assign winner_onehot[gi] = (winner == 3'(gi));
        end
    endgenerate

    always_comb begin
        win_off = 3'd0;
        // Descending scan so the lowest set offset wins.
        for (int k = 7; k >= 0; k--) begin
            if (rot_req[k]) begin
                win_off = 3'(k);
            end
        end
        winner = last_reg + win_off + 3'd1;
    end

    // ------------------------------------------------------------------
    // Datapath and handshake. Reset gates the combinational outputs so
    // nothing looks active (and no transfer happens) during a reset cycle,
    // even if the registers still hold BUSY.
    // ------------------------------------------------------------------
    logic owner_req;
    logic transfer;
    logic release_now;

    assign busy        = (state_reg == BUSY) && !rst;
    assign owner_req   = req[out_sel_reg];
    assign out_valid   = busy && owner_req;
    assign out_data    = busy ? data_in[out_sel_reg] : 1'b0;
    assign transfer    = out_valid && out_ready;
    // Release when the owner withdraws, or on the final allowed transfer.
    assign release_now = busy && (!owner_req || (transfer && (beat_cnt_reg == LAST_BEAT)));

    assign gnt     = gnt_reg;
    assign out_sel = out_sel_reg;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        last_next     = last_reg;
        beat_cnt_next = beat_cnt_reg;
        gnt_next      = gnt_reg;
        out_sel_next  = out_sel_reg;

        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next    = BUSY;
                    out_sel_next  = winner;
                    gnt_next      = winner_onehot;
                    beat_cnt_next = 4'd0;
                end
            end
            BUSY: begin
                if (release_now) begin
                    // out_sel is left alone so the datapath select holds.
                    state_next    = IDLE;
                    last_next     = out_sel_reg;
                    gnt_next      = 8'd0;
                    beat_cnt_next = 4'd0;
                end else if (transfer) begin
                    beat_cnt_next = beat_cnt_reg + 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = 8'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers. last resets to 7 so the first search starts at 0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            last_reg     <= 3'd7;
            beat_cnt_reg <= 4'd0;
            gnt_reg      <= 8'd0;
            out_sel_reg  <= 3'd0;
        end else begin
            state_reg    <= state_next;
            last_reg     <= last_next;
            beat_cnt_reg <= beat_cnt_next;
            gnt_reg      <= gnt_next;
            out_sel_reg  <= out_sel_next;
        end
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mux8_rr_arbiter
//
// Directed bench for mux8_rr_arbiter. A MAX_BEATS=4 instance runs a table of
// per-cycle vectors plus hand-written multi-cycle sequences; a MAX_BEATS=1
// instance checks single-beat alternation. Inputs change on the falling edge
// and outputs are sampled 1 time unit later, away from the rising edge.
// ----------------------------------------------------------------------------
module tb_mux8_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;

    logic [7:0] req,       req1;
    logic [7:0] data_in,   data_in1;
    logic       out_ready, out_ready1;
    logic [7:0] gnt,       gnt1;
    logic [2:0] out_sel,   out_sel1;
    logic       out_valid, out_valid1;
    logic       out_data,  out_data1;
    logic       busy,      busy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux8_rr_arbiter #(.MAX_BEATS(4)) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .out_ready(out_ready),
        .gnt(gnt), .out_sel(out_sel), .out_valid(out_valid), .out_data(out_data), .busy(busy)
    );

    mux8_rr_arbiter #(.MAX_BEATS(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .data_in(data_in1), .out_ready(out_ready1),
        .gnt(gnt1), .out_sel(out_sel1), .out_valid(out_valid1), .out_data(out_data1), .busy(busy1)
    );

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] data_in;
        logic       out_ready;
        logic [7:0] exp_gnt;
        logic [2:0] exp_sel;
        logic       exp_busy;
        logic       exp_valid;
        logic       exp_data;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock: through the rising edge to the next falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 8'h00; data_in = 8'h00; out_ready = 1'b0;
        req1 = 8'h00; data_in1 = 8'h00; out_ready1 = 1'b0;
        @(negedge clk);

        // ------------------------------------------------------------
        // Table: two requesters 0 and 7, MAX_BEATS=4, sink always ready.
        //            rst  req    data   rdy  gnt    sel  busy vld dat
        vecs[0]  = '{1'b1, 8'h81, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'h81, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h81, 8'h01, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 8'h83, 8'h80, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 8'h81, 8'h01, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 8'h81, 8'h01, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 8'h81, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h81, 8'h80, 1'b1, 8'h80, 3'd7, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 8'h81, 8'h7F, 1'b1, 8'h80, 3'd7, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 8'h81, 8'h80, 1'b1, 8'h80, 3'd7, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 8'h81, 8'h80, 1'b1, 8'h80, 3'd7, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 8'h81, 8'hFF, 1'b1, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 8'h81, 8'h01, 1'b1, 8'h01, 3'd0, 1'b1, 1'b1, 1'b1};

        // Two reset edges so every register is defined before row 0.
        tick();
        tick();
        for (int i = 0; i < 13; i++) begin
            rst = vecs[i].rst; req = vecs[i].req;
            data_in = vecs[i].data_in; out_ready = vecs[i].out_ready;
            #1;
            $display("vec %0d: req=%h gnt=%h sel=%0d busy=%b valid=%b data=%b",
                     i, req, gnt, out_sel, busy, out_valid, out_data);
            chk($sformatf("vec%0d gnt", i),   gnt,       vecs[i].exp_gnt);
            chk($sformatf("vec%0d sel", i),   8'(out_sel), 8'(vecs[i].exp_sel));
            chk($sformatf("vec%0d busy", i),  8'(busy),      8'(vecs[i].exp_busy));
            chk($sformatf("vec%0d valid", i), 8'(out_valid), 8'(vecs[i].exp_valid));
            chk($sformatf("vec%0d data", i),  8'(out_data),  8'(vecs[i].exp_data));
            tick();
        end

        // ------------------------------------------------------------
        // All eight requesting: order 0..7 then 0, 4 beats each.
        req = 8'hFF; out_ready = 1'b1; data_in = 8'h00;
        do_reset();
        for (int g = 0; g < 9; g++) begin
            #1;
            chk($sformatf("rr%0d idle busy", g), 8'(busy), 8'd0);
            chk($sformatf("rr%0d idle gnt", g), gnt, 8'h00);
            tick();
            for (int b = 0; b < 4; b++) begin
                #1;
                chk($sformatf("rr%0d b%0d gnt", g, b), gnt, 8'(1 << (g % 8)));
                chk($sformatf("rr%0d b%0d sel", g, b), 8'(out_sel), 8'(g % 8));
                tick();
            end
            $display("rr grant %0d: requester %0d held 4 beats", g, g % 8);
        end

        // ------------------------------------------------------------
        // Combinational datapath: owner 3, data flips within a cycle.
        req = 8'h08; out_ready = 1'b0; data_in = 8'b0000_1000;
        do_reset();
        tick();
        #1;
        chk("dp gnt3", gnt, 8'h08);
        chk("dp data hi", 8'(out_data), 8'd1);
        data_in = 8'h00;
        #1;
        chk("dp data lo", 8'(out_data), 8'd0);
        $display("datapath: owner 3 data follows data_in[3]");
        tick();

        // ------------------------------------------------------------
        // Stall: owner 2 with sink not ready, then request withdrawn.
        req = 8'h04; out_ready = 1'b0; data_in = 8'h00;
        do_reset();
        tick();
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("stall%0d gnt", c), gnt, 8'h04);
            chk($sformatf("stall%0d beat", c), 8'(dut.beat_cnt_reg), 8'd0);
            tick();
        end
        req = 8'h00;
        #1;
        chk("drop valid", 8'(out_valid), 8'd0);
        tick();
        #1;
        chk("drop busy", 8'(busy), 8'd0);
        chk("drop gnt", gnt, 8'h00);
        chk("drop last", 8'(dut.last_reg), 8'd2);
        // Search now starts at 3: of {1,2}, 1 comes first after wrapping.
        req = 8'h06;
        tick();
        #1;
        chk("after drop gnt", gnt, 8'h02);
        $display("stall: 10 cycles held, release on drop, next grant %h", gnt);

        // ------------------------------------------------------------
        // Reset mid-grant: owner 5 after 2 beats.
        req = 8'h20; out_ready = 1'b1; data_in = 8'hFF;
        do_reset();
        tick();
        #1;
        chk("mid gnt5", gnt, 8'h20);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mid rst busy", 8'(busy), 8'd0);
        chk("mid rst valid", 8'(out_valid), 8'd0);
        chk("mid rst data", 8'(out_data), 8'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid post gnt", gnt, 8'h00);
        chk("mid post beat", 8'(dut.beat_cnt_reg), 8'd0);
        tick();
        for (int b = 0; b < 4; b++) begin
            #1;
            chk($sformatf("mid regrant b%0d", b), gnt, 8'h20);
            tick();
        end
        #1;
        chk("mid regrant release", 8'(busy), 8'd0);
        $display("reset mid-grant: regrant to 5 ran full 4 beats");

        // ------------------------------------------------------------
        // MAX_BEATS=1: requesters 1 and 2 alternate with idle gaps.
        req = 8'h00;
        req1 = 8'h06; out_ready1 = 1'b1; data_in1 = 8'h00;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            logic [7:0] exp_g;
            case (c)
                1, 5:    exp_g = 8'h02;
                3, 7:    exp_g = 8'h04;
                default: exp_g = 8'h00;
            endcase
            #1;
            chk($sformatf("mb1 c%0d gnt", c), gnt1, exp_g);
            $display("mb1 cycle %0d: gnt=%h", c, gnt1);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux8_rr_arbiter.md
MUX8_RR_ARBITER -- requirements
Module: mux8_rr_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_BEATS, default 4, giving the maximum transfers per grant; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req, input, 8 bits: request from requester i on req[i].
REQ-005 The block SHALL have port data_in, input, 8 bits: data bit of requester i on data_in[i], the 8:1 datapath inputs.
REQ-006 The block SHALL have port out_ready, input, 1 bit: sink accepts the current beat.
REQ-007 The block SHALL have port gnt, output, 8 bits: one-hot grant, registered.
REQ-008 The block SHALL have port out_sel, output, 3 bits: registered select of the 8:1 datapath (index of granted requester).
REQ-009 The block SHALL have port out_valid, output, 1 bit: beat available to sink.
REQ-010 The block SHALL have port out_data, output, 1 bit: data_in[out_sel] while busy, else 0.
REQ-011 The block SHALL have port busy, output, 1 bit: high in state BUSY.

Function
REQ-012 The FSM SHALL have two states: IDLE and BUSY.
REQ-013 Internal state SHALL be: last[2:0] (last granted index), beat_cnt[3:0].
REQ-014 In IDLE with req==0, the state SHALL be held; gnt=0, out_valid=0, out_data=0.
REQ-015 In IDLE with req!=0, the winner SHALL be the first set req[i] searching i = last+1, last+2, ... modulo 8 (wrap 7->0).
REQ-016 On the edge after a winner is found: state<=BUSY, out_sel<=winner, gnt<=one-hot(winner), beat_cnt<=0; request-to-grant latency is 1 cycle.
REQ-017 out_valid SHALL equal busy AND req[out_sel], combinationally.
REQ-018 out_data SHALL equal data_in[out_sel] when busy, else 0, combinationally, with no added latency.
REQ-019 A transfer SHALL be a cycle with out_valid=1 and out_ready=1; each transfer increments beat_cnt by 1.
REQ-020 Release SHALL occur on the edge of a BUSY cycle where req[out_sel]=0, or where a transfer occurs with beat_cnt==MAX_BEATS-1.
REQ-021 On release: state<=IDLE, last<=out_sel, gnt<=0, beat_cnt<=0.
REQ-022 There SHALL be one mandatory IDLE cycle between grants; no back-to-back regrant.
REQ-023 Requests from non-granted requesters arriving during BUSY SHALL NOT affect gnt or out_sel.
REQ-024 out_sel SHALL hold its last value in IDLE; only gnt and busy indicate ownership.
REQ-025 With out_ready low, the grant SHALL be held indefinitely while req[out_sel] remains high; there is no timeout.
REQ-026 A single persistent requester SHALL be regranted after each release, since the round-robin search wraps to itself.

Reset
REQ-027 When rst=1 at a clock edge: state<=IDLE, last<=7, beat_cnt<=0, gnt<=0, out_sel<=0.
REQ-028 While in reset: out_valid=0, out_data=0, busy=0.
REQ-029 rst SHALL take priority over all other events, including mid-BUSY; no transfer is counted in the reset cycle.
REQ-030 After reset the first search SHALL start at index 0.

Verification
REQ-031 Reset, then req=8'h81 held, out_ready=1, MAX_BEATS=4 -> gnt=8'h01 for 4 transfers; 1 IDLE cycle; gnt=8'h80 for 4 transfers; 1 IDLE cycle; gnt=8'h01.
REQ-032 req=8'hFF, out_ready=1 -> grant order 0,1,2,...,7,0, each holding 4 beats, out_sel matching gnt index.
REQ-033 Granted to 3 with data_in=8'b0000_1000 -> out_data=1; flip data_in[3]=0 -> out_data=0 the same cycle.
REQ-034 Granted to 2, out_ready=0 for 10 cycles -> beat_cnt stays 0 and gnt=8'h04 throughout; drop req[2] -> IDLE next edge, last=2.
REQ-035 Granted to 5 after 2 beats, rst=1 for one cycle -> gnt=0, busy=0; with req=8'h20 still high, next grant is to 5 starting at beat 0.
REQ-036 MAX_BEATS=1, req=8'h06, out_ready=1 -> grants alternate 1,2,1,2 with one beat each and one IDLE cycle between grants.
